// File: rtl/wts_adsr_pkg.sv
// Shared types and constants for the WTS ADSR envelope generator.
package wts_adsr_pkg;

  localparam int ENV_W = 8;
  localparam logic [ENV_W-1:0] ENV_MAX = 8'd128;

  // Phase encoding is also what the optional state port exposes.
  typedef enum logic [2:0] {
    PhIdle    = 3'd0,
    PhAttack  = 3'd1,
    PhDecay   = 3'd2,
    PhSustain = 3'd3,
    PhRelease = 3'd4
  } phase_e;

endpackage

// File: rtl/wts_adsr_rate_counter.sv
// Shared ADSR rate divider: emits one step every i_rate active ticks; rate 0 never steps.
module wts_adsr_rate_counter (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_active,
  input  logic       i_clear,
  input  logic [7:0] i_rate,
  output logic       o_step
);

  logic [7:0] r_count;
  logic [8:0] w_count_inc;

  assign w_count_inc = {1'b0, r_count} + 9'd1;

  // Step decision ignores i_clear so the top can derive clear from the step without a loop.
  // The >= lets a lowered rate take effect on the very next tick.
  assign o_step = i_active && (i_rate != 8'd0) && (w_count_inc >= {1'b0, i_rate});

  // Counter: cleared on phase change or step, held while the rate is zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= 8'd0;
    end else if (i_active) begin
      if (i_clear || o_step) begin
        r_count <= 8'd0;
      end else if (i_rate != 8'd0) begin
        r_count <= w_count_inc[7:0];
      end
    end
  end

endmodule

// File: rtl/wts_adsr_envelope_generator.sv
// Per-channel ADSR envelope generator producing a 0..128 level, updated on active ticks.
// Optional macro WTS_ADSR_STATE_OUT_EN adds the registered o_state phase output.
module wts_adsr_envelope_generator
  import wts_adsr_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_active,
  input  logic             i_key_on,
  input  logic             i_key_release,
  input  logic             i_key_off,
  input  logic [7:0]       i_reg_ar,
  input  logic [7:0]       i_reg_dr,
  input  logic [7:0]       i_reg_sr,
  input  logic [7:0]       i_reg_rr,
  input  logic [6:0]       i_reg_sl,
  output logic [ENV_W-1:0] o_envelope
`ifdef WTS_ADSR_STATE_OUT_EN
  ,
  output logic [2:0]       o_state
`endif
);

  phase_e           r_phase;
  phase_e           w_phase_d;
  logic [ENV_W-1:0] r_env;
  logic [ENV_W-1:0] w_env_d;
  logic [7:0]       w_rate;
  logic             w_step;
  logic             w_restart;
  logic             w_clear;

  // Rate source for the current phase; idle never steps.
  always_comb begin
    w_rate = 8'd0;
    unique case (r_phase)
      PhAttack:  w_rate = i_reg_ar;
      PhDecay:   w_rate = i_reg_dr;
      PhSustain: w_rate = i_reg_sr;
      PhRelease: w_rate = i_reg_rr;
      default:   w_rate = 8'd0;
    endcase
  end

  wts_adsr_rate_counter u_rate_counter (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_active (i_active),
    .i_clear  (w_clear),
    .i_rate   (w_rate),
    .o_step   (w_step)
  );

  // Next phase/level: key events first (off > on > release), then the phase's own stepping.
  always_comb begin
    w_phase_d = r_phase;
    w_env_d   = r_env;
    w_restart = 1'b0;
    if (i_key_off) begin
      w_phase_d = PhIdle;
      w_env_d   = '0;
      w_restart = 1'b1;
    end else if (i_key_on) begin
      w_restart = 1'b1;
      if (i_reg_ar == 8'd0) begin
        w_phase_d = PhDecay;
        w_env_d   = ENV_MAX;
      end else begin
        w_phase_d = PhAttack;
      end
    end else if (i_key_release &&
                 (r_phase == PhAttack || r_phase == PhDecay || r_phase == PhSustain)) begin
      w_phase_d = PhRelease;
    end else begin
      unique case (r_phase)
        PhAttack: begin
          if (w_step) begin
            // Clamp also covers a key_on that restarted attack at full level.
            if (r_env >= ENV_MAX - 8'd1) begin
              w_env_d   = ENV_MAX;
              w_phase_d = PhDecay;
            end else begin
              w_env_d = r_env + 8'd1;
            end
          end
        end
        PhDecay: begin
          if (r_env <= {1'b0, i_reg_sl}) begin
            w_phase_d = PhSustain;
          end else if (w_step) begin
            w_env_d = r_env - 8'd1;
            if (r_env == 8'd1) w_phase_d = PhIdle;
          end
        end
        PhSustain, PhRelease: begin
          if (r_env == '0) begin
            w_phase_d = PhIdle;
          end else if (w_step) begin
            w_env_d = r_env - 8'd1;
            if (r_env == 8'd1) w_phase_d = PhIdle;
          end
        end
        default: begin
          w_env_d = '0;
        end
      endcase
    end
  end

  // Any phase change or key restart starts the rate count afresh.
  assign w_clear = i_active && (w_restart || (w_phase_d != r_phase));

  // Phase and level registers advance only on active ticks.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= PhIdle;
      r_env   <= '0;
    end else if (i_active) begin
      r_phase <= w_phase_d;
      r_env   <= w_env_d;
    end
  end

  assign o_envelope = r_env;
`ifdef WTS_ADSR_STATE_OUT_EN
  assign o_state = r_phase;
`endif

endmodule

// File: tb/tb_wts_adsr_envelope_generator.sv
// Self-checking bench for wts_adsr_envelope_generator with a behavioural envelope model.
module tb_wts_adsr_envelope_generator;

  logic       clk;
  logic       i_reset;
  logic       i_active;
  logic       i_key_on;
  logic       i_key_release;
  logic       i_key_off;
  logic [7:0] ar, dr, sr, rr;
  logic [6:0] sl;
  logic [7:0] envelope;
`ifdef WTS_ADSR_STATE_OUT_EN
  logic [2:0] state;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model state: phase 0..4 (idle, attack, decay, sustain, release), level, tick count.
  int m_ph  = 0;
  int m_env = 0;
  int m_cnt = 0;

  wts_adsr_envelope_generator dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_active      (i_active),
    .i_key_on      (i_key_on),
    .i_key_release (i_key_release),
    .i_key_off     (i_key_off),
    .i_reg_ar      (ar),
    .i_reg_dr      (dr),
    .i_reg_sr      (sr),
    .i_reg_rr      (rr),
    .i_reg_sl      (sl),
    .o_envelope    (envelope)
`ifdef WTS_ADSR_STATE_OUT_EN
    ,
    .o_state       (state)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // One active tick of the envelope rules, in plain integer arithmetic.
  task automatic model_next(input int ph, input int env, input int cnt,
                            output int nph, output int nenv, output int ncnt);
    int rates[5];
    rates = '{0, int'(ar), int'(dr), int'(sr), int'(rr)};
    nph = ph; nenv = env; ncnt = cnt;
    if (i_key_off) begin
      nph = 0; nenv = 0; ncnt = 0;
    end else if (i_key_on) begin
      ncnt = 0;
      if (ar == 0) begin nenv = 128; nph = 2; end
      else nph = 1;
    end else if (i_key_release && ph >= 1 && ph <= 3) begin
      nph = 4; ncnt = 0;
    end else if (ph == 2 && env <= int'(sl)) begin
      nph = 3; ncnt = 0;
    end else if ((ph == 3 || ph == 4) && env == 0) begin
      nph = 0; ncnt = 0;
    end else if (ph != 0 && rates[ph] != 0) begin
      ncnt = cnt + 1;
      if (ncnt >= rates[ph]) begin
        ncnt = 0;
        nenv = (ph == 1) ? env + 1 : env - 1;
        if (nenv >= 128) begin nenv = 128; nph = 2; end
        if (nenv <= 0) begin nenv = 0; nph = 0; end
      end
    end
  endtask

  always @(posedge clk) begin
    int nph, nenv, ncnt;
    if (i_reset) begin
      m_ph <= 0; m_env <= 0; m_cnt <= 0;
    end else if (i_active) begin
      model_next(m_ph, m_env, m_cnt, nph, nenv, ncnt);
      m_ph <= nph; m_env <= nenv; m_cnt <= ncnt;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (int'(envelope) !== m_env) begin
        n_err++;
        $display("FAIL envelope @%0t: got %0d expected %0d", $time, envelope, m_env);
      end
`ifdef WTS_ADSR_STATE_OUT_EN
      n_cmp++;
      if (int'(state) !== m_ph) begin
        n_err++;
        $display("FAIL state @%0t: got %0d expected %0d", $time, state, m_ph);
      end
`endif
    end
  end

  task automatic check_lit(input string name, input int exp);
    n_cmp++;
    if (int'(envelope) !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, envelope, exp);
    end
  endtask

  // One active tick with the given keys, then 0..2 idle cycles carrying random key noise.
  task automatic tick(input bit on = 0, input bit rel = 0, input bit off = 0);
    int gap;
    @(negedge clk);
    i_active = 1; i_key_on = on; i_key_release = rel; i_key_off = off;
    @(negedge clk);
    i_active = 0; i_key_on = 0; i_key_release = 0; i_key_off = 0;
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      i_key_on = 1'($urandom_range(0, 1));
      i_key_release = 1'($urandom_range(0, 1));
      i_key_off = 1'($urandom_range(0, 1));
      @(negedge clk);
      i_key_on = 0; i_key_release = 0; i_key_off = 0;
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_regs(input int a, input int d, input int l, input int s, input int r);
    ar = 8'(a); dr = 8'(d); sl = 7'(l); sr = 8'(s); rr = 8'(r);
  endtask

  initial begin
    i_reset = 1; i_active = 0; i_key_on = 0; i_key_release = 0; i_key_off = 0;
    set_regs(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    i_reset = 0;
    chk_en = 1;

    // 1: quiet after reset
    check_lit("reset_env", 0);
    ticks(50);
    check_lit("idle_50", 0);

    // 2: instant attack, holds with zero rates, key_off mutes
    tick(1, 0, 0);
    check_lit("instant_attack", 128);
    ticks(50);
    check_lit("dr0_hold", 128);
    tick(0, 1, 0);
    ticks(20);
    check_lit("rr0_hold", 128);
    tick(0, 0, 1);
    check_lit("key_off_mute", 0);
    ticks(10);
    check_lit("off_hold", 0);

    // 3: full ADSR cycle
    set_regs(2, 3, 100, 100, 4);
    tick(1, 0, 0);
    ticks(255);
    check_lit("attack_255", 127);
    tick();
    check_lit("attack_256", 128);
    ticks(83);
    check_lit("decay_83", 101);
    tick();
    check_lit("decay_84", 100);
    ticks(2500 - 340);
    tick(0, 1, 0);
    ticks(400);
    check_lit("release_done", 0);

    // 4: decay straight to zero, then release ignored
    set_regs(0, 3, 0, 0, 3);
    tick(1, 0, 0);
    check_lit("t4_instant", 128);
    ticks(383);
    check_lit("t4_decay_383", 1);
    tick();
    check_lit("t4_decay_384", 0);
    tick(0, 1, 0);
    ticks(10);
    check_lit("t4_release_ignored", 0);

    // 5: attack rate 1, sustain hold, release rate 3
    set_regs(1, 3, 100, 0, 0);
    tick(1, 0, 0);
    ticks(128);
    check_lit("t5_attack", 128);
    ticks(84);
    check_lit("t5_sl", 100);
    ticks(200);
    check_lit("t5_hold", 100);
    rr = 8'd3;
    tick(0, 1, 0);
    ticks(299);
    check_lit("t5_rel_299", 1);
    tick();
    check_lit("t5_rel_300", 0);

    // 6: priority and attack resume from release level
    tick(1, 0, 1);
    check_lit("on_off_same_tick", 0);
    set_regs(0, 0, 0, 0, 1);
    tick(1, 0, 0);
    tick(0, 1, 0);
    ticks(78);
    check_lit("release_to_50", 50);
    ar = 8'd1;
    tick(1, 0, 0);
    check_lit("resume_50", 50);
    ticks(77);
    check_lit("resume_127", 127);
    tick();
    check_lit("resume_128", 128);

    // Random keys, register changes and resets, checked by the model every cycle.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) == 0) begin
        set_regs($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 127),
                 $urandom_range(0, 5), $urandom_range(0, 5));
      end
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk);
        i_reset = 1; i_active = 1'($urandom_range(0, 1)); i_key_on = 1;
        @(negedge clk);
        i_reset = 0; i_active = 0; i_key_on = 0;
      end
      tick($urandom_range(0, 31) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 63) == 0);
    end

    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
